// File: rtl/lram_buf_pkg.sv
// Shared types and constants for the LRAM-backed stream buffer.
// Pointer wrap is an explicit compare because DEPTH need not be a power of two.
package lram_buf_pkg;

  typedef enum logic {WR = 1'b0, RD = 1'b1} grant_t;

  localparam int RAM_RD_LAT = 1;
  localparam int OQ_DEPTH   = 2;

  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/lram_buf_outq.sv
// Two-entry output queue holding prefetched RAM words ahead of the output stream.
// Simultaneous push and pop are both honoured; the write slot is the head when full.
module lram_buf_outq import lram_buf_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_rdy,
  output logic [1:0]        cnt,
  output logic [DATA_W-1:0] head,
  output logic              valid
);

  logic [OQ_DEPTH-1:0][DATA_W-1:0] mem;
  logic rd_idx;
  logic wr_idx;
  logic pop;

  assign valid  = cnt != 2'd0;
  assign pop    = valid && pop_rdy;
  assign wr_idx = rd_idx ^ cnt[0];
  assign head   = mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      rd_idx <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) mem[wr_idx] <= push_data;
      if (pop)  rd_idx <= ~rd_idx;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/lram_stream_buf.sv
// Valid/ready FIFO built on a single-port LRAM: arbitrates one write or read per
// cycle and prefetches read data into a 2-entry output queue.
module lram_stream_buf import lram_buf_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W+1:0] level,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              rd_inflight;
  grant_t            last_grant;
  logic [1:0]        oq_cnt;
  logic [2:0]        oq_pend;
  logic              rd_req, wr_req, wr_gnt, rd_gnt;

  // Reads are throttled so the queue can always absorb every in-flight word.
  assign oq_pend = {1'b0, oq_cnt} + {2'b00, rd_inflight};
  assign rd_req  = !rst && ram_cnt != '0 && oq_pend < 3'(OQ_DEPTH);
  assign wr_req  = !rst && s_valid && ram_cnt != DEPTH_C;
  assign wr_gnt  = wr_req && (!rd_req || last_grant == RD);
  assign rd_gnt  = rd_req && (!wr_req || last_grant == WR);

  // Independent of s_valid: a pending read that owns the next contested slot blocks input.
  assign s_ready = !rst && ram_cnt != DEPTH_C && !(rd_req && last_grant == WR);

  always_comb begin
    ram_ce    = wr_gnt || rd_gnt;
    ram_we    = wr_gnt;
    ram_addr  = '0;
    ram_wdata = '0;
    if (wr_gnt) begin
      ram_addr  = wr_ptr;
      ram_wdata = s_data;
    end else if (rd_gnt) begin
      ram_addr  = rd_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      last_grant  <= RD;
    end else begin
      if (wr_gnt) wr_ptr <= ADDR_W'(ptr_wrap(32'(wr_ptr), DEPTH));
      if (rd_gnt) rd_ptr <= ADDR_W'(ptr_wrap(32'(rd_ptr), DEPTH));
      case ({wr_gnt, rd_gnt})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      rd_inflight <= rd_gnt;
      if (wr_req && rd_req) last_grant <= wr_gnt ? WR : RD;
    end
  end

  lram_buf_outq #(.DATA_W(DATA_W)) u_outq (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight),
    .push_data (ram_rdata),
    .pop_rdy   (m_ready),
    .cnt       (oq_cnt),
    .head      (m_data),
    .valid     (m_valid)
  );

  assign level = (ADDR_W+2)'(ram_cnt) + (ADDR_W+2)'(oq_cnt) + (ADDR_W+2)'(rd_inflight);
  assign full  = ram_cnt == DEPTH_C;
  assign empty = level == '0;

endmodule

// File: doc/lram_stream_buf.md
# lram_stream_buf

Streaming FIFO controller that sits directly upstream of a single LRAM_CORE and turns the LRAM into a deep valid/ready buffer. It converts a valid/ready input stream into single-port LRAM write and read cycles, and prefetches read data into a 2-entry output queue. It presents a valid/ready output stream with full throughput when input and output are not both active. Used in LIFCL test designs that exercise LRAM with realistic, backpressured traffic.

## Interface
Parameters:
- `DATA_W`, 32: word width; matches the LRAM data port.
- `ADDR_W`, 14: LRAM address width.
- `DEPTH`, 16384: RAM words used; must be ≤ 2^ADDR_W and ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  input accept.
- `s_data`  in  DATA_W  input word.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  output accept.
- `m_data`  out  DATA_W  output word.
- `ram_ce`  out  1  LRAM clock enable / access strobe.
- `ram_we`  out  1  LRAM write enable (qualified by `ram_ce`).
- `ram_addr`  out  ADDR_W  LRAM address.
- `ram_wdata`  out  DATA_W  LRAM write data.
- `ram_rdata`  in  DATA_W  LRAM read data, valid the cycle after a read access.
- `level`  out  ADDR_W+2  total words held (RAM + in-flight + output queue).
- `full`  out  1  RAM region holds DEPTH words.
- `empty`  out  1  `level == 0`.

## Operation
- State:
  - `wr_ptr` and `rd_ptr`, each 0..DEPTH-1, wrapping DEPTH-1 → 0. Wrap is not a power-of-2 mask.
  - `ram_cnt`, 0..DEPTH.
  - `rd_inflight` bit.
  - 2-entry output queue with occupancy `oq_cnt` (0..2).
  - `last_grant` (WR/RD).
- Requests:
  - `rd_req = ram_cnt != 0 && (oq_cnt + rd_inflight) < 2`.
  - `wr_req = s_valid && ram_cnt != DEPTH`.
- Arbitration, one RAM access per cycle:
  - If only one request is active, it wins.
  - If both are active, the one opposite to `last_grant` wins.
  - `last_grant` updates only on a contested cycle.
- `s_ready = !rst && ram_cnt != DEPTH && !(rd_req && last_grant == WR)`. There is no combinational path from `s_valid` to `s_ready`.
- Write grant: `ram_ce = ram_we = 1`, `ram_addr = wr_ptr`, `ram_wdata = s_data`. `wr_ptr` advances and `ram_cnt` increments.
- Read grant: `ram_ce = 1`, `ram_we = 0`, `ram_addr = rd_ptr`. `rd_ptr` advances, `ram_cnt` decrements, and `rd_inflight` is set.
- Next cycle, `ram_rdata` is pushed into the output queue and `rd_inflight` is cleared.
- Output queue:
  - `m_valid = oq_cnt != 0`; `m_data` = head entry.
  - A pop on `m_valid && m_ready` and a push in the same cycle are both honoured.
- Reset values:
  - Pointers, counts, `rd_inflight`, `oq_cnt`: 0.
  - `last_grant`: RD.
  - `ram_ce`, `ram_we`, `m_valid`, `s_ready`, `full`: 0.
  - `empty`: 1.
  - `ram_addr`, `ram_wdata`: 0.
- Reset mid-operation discards all contents. Any in-flight `ram_rdata` in the cycle after deassertion is ignored.

## Timing
- RAM port outputs are combinational from registered state plus `s_data`/`s_valid`. The LRAM registers them at the edge.
- First-word latency into an empty buffer:
  - Accept at cycle t; read at t+1; data captured at the end of t+2.
  - `m_valid` is high from t+3.
- Throughput:
  - 1 word/cycle in one direction when the other direction is idle.
  - 1 word per 2 cycles each way when both directions are contested.
- `full`:
  - Asserts the cycle after the DEPTH-th write lands.
  - Deasserts the cycle after a read grant.
- Simultaneous write grant and output pop: `level` is unchanged.

## Structure
- Package `lram_buf_pkg`:
  - `grant_t` enum (WR, RD).
  - `RAM_RD_LAT = 1`.
  - `OQ_DEPTH = 2`.
  - The pointer-wrap helper function.
- Sub-module `lram_buf_outq`: the 2-entry output queue (push, pop, count, head data).
- The top module holds pointers, counters, the arbiter and the RAM port drive.

## Test plan
- Reset then idle → all outputs at their reset values; `s_ready` = 1 on the first cycle after `rst` falls; no `ram_ce`.
- Single word 0xA5A5_0001 with `m_ready` = 1 → `ram_we` at addr 0; read of addr 0 the next cycle; `m_valid` 3 cycles after accept with correct data; `empty` returns to 1.
- Burst of 8 words with `m_ready` = 0 → 8 writes, 2 reads prefetched, `level` = 8. Then `m_ready` = 1 → the 8 words emerge in order.
- Fill with DEPTH = 16 (parameter override) and `m_ready` = 0 → after 16 RAM words plus 2 queued (`level` 18), `full` = 1 and `s_ready` = 0. One pop → a read is granted and `full` drops.
- Continuous `s_valid` and `m_ready` → grants alternate WR/RD; no reordering or loss over 1000 words; pointers wrap past DEPTH-1 correctly.
- Assert `rst` while `rd_inflight` = 1 and `oq_cnt` = 2 → all state cleared; the stale `ram_rdata` after reset is not pushed; `m_valid` stays 0.
